// File: rtl/button_conditioner.sv
// Button front end: 2-flop sync, per-channel debounce, rising-edge pulses with lowest-index arbitration.
// Define BTN_AUTO_REPEAT_EN to compile in auto-repeat on the add channels (bits 0..3).
module button_conditioner #(
    parameter int DB_CYCLES     = 3,
    parameter int REPEAT_DELAY  = 100,
    parameter int REPEAT_PERIOD = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn_raw,
    output logic [5:0] pulse,
    output logic [5:0] held,
    output logic       any_pulse
);

    localparam int         NCH     = 6;
    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    generate
        if (DB_CYCLES < 1 || DB_CYCLES > 255 ||
            REPEAT_DELAY < 2 || REPEAT_DELAY > 4095 ||
            REPEAT_PERIOD < 2 || REPEAT_PERIOD > 4095) begin : g_bad_params
            $error("button_conditioner: parameter out of legal range");
        end
    endgenerate

    logic [5:0] r_sync1;
    logic [5:0] r_sync2;
    logic [5:0] r_heldPrev;
    logic [7:0] r_dbCnt [NCH];
    logic [5:0] w_rise;
    logic [5:0] w_req;
    logic [5:0] w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // held only flips after DB_CYCLES consecutive samples disagreeing with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
            for (int i = 0; i < NCH; i++) r_dbCnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (r_sync2[i] == held[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DB_LAST) begin
                    held[i]    <= ~held[i];
                    r_dbCnt[i] <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_heldPrev <= '0;
        else     r_heldPrev <= held;
    end

    assign w_rise = held & ~r_heldPrev;

`ifdef BTN_AUTO_REPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} repState_t;

    localparam logic [11:0] DELAY_LAST  = 12'(REPEAT_DELAY - 1);
    localparam logic [11:0] PERIOD_LAST = 12'(REPEAT_PERIOD - 1);

    repState_t   r_repState [4];
    repState_t   w_repNext  [4];
    logic [11:0] r_repCnt   [4];
    logic [3:0]  w_repReq;

    // The timer keeps running even when arbitration drops a repeat request.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_repState[i] <= IDLE;
                r_repCnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_repState[i] <= w_repNext[i];
                if (w_repNext[i] != r_repState[i] ||
                    (r_repState[i] == REPEAT && r_repCnt[i] == PERIOD_LAST))
                    r_repCnt[i] <= '0;
                else if (r_repState[i] != IDLE)
                    r_repCnt[i] <= r_repCnt[i] + 12'd1;
            end
        end
    end

    always_comb begin
        w_repNext = r_repState;
        for (int i = 0; i < 4; i++) begin
            case (r_repState[i])
                IDLE:    if (w_rise[i]) w_repNext[i] = DELAY;
                DELAY:   if (!held[i]) w_repNext[i] = IDLE;
                         else if (r_repCnt[i] == DELAY_LAST) w_repNext[i] = REPEAT;
                REPEAT:  if (!held[i]) w_repNext[i] = IDLE;
                default: w_repNext[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        w_repReq = '0;
        for (int i = 0; i < 4; i++) begin
            w_repReq[i] = held[i] &&
                          ((r_repState[i] == DELAY  && r_repCnt[i] == DELAY_LAST) ||
                           (r_repState[i] == REPEAT && r_repCnt[i] == PERIOD_LAST));
        end
    end

    assign w_req = w_rise | {2'b00, w_repReq};
`else
    assign w_req = w_rise;
`endif

    // Isolate the lowest set request bit; everything else is dropped.
    assign w_grant = w_req & (~w_req + 6'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse     <= '0;
            any_pulse <= 1'b0;
        end else begin
            pulse     <= w_grant;
            any_pulse <= |w_grant;
        end
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 3: consecutive stable cycles required to accept a level change (legal range 1..255).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 100: held cycles before the first auto-repeat pulse (legal range 2..4095).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 25: cycles between later auto-repeat pulses (legal range 2..4095).
REQ-004 Port clk  input  1  system clock, the same clock as the downstream meter.
REQ-005 Port rst  input  1  reset; synchronous, active-high; clock clk.
REQ-006 Port btn_raw  input  6  asynchronous raw buttons; bit0..3 = add1..add4, bit4 = rst1, bit5 = rst2.
REQ-007 Port pulse  output  6  registered single-cycle command pulses, same bit order as btn_raw, fed directly to the meter.
REQ-008 Port held  output  6  debounced button levels.
REQ-009 Port any_pulse  output  1  registered OR of pulse.

Function
REQ-010 Each bit of btn_raw SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each channel SHALL keep an 8-bit stability counter, updated at every edge:
- synchronized value differs from held: counter increments.
- synchronized value equals held: counter clears to 0.
- mismatch while counter == DB_CYCLES-1: held toggles and counter clears.
REQ-012 A glitch shorter than DB_CYCLES cycles SHALL leave held unchanged.
REQ-013 A rising edge of held SHALL raise a pulse request for that channel; a falling edge SHALL raise no request.
REQ-014 pulse SHALL be high for exactly one cycle per accepted request.
REQ-015 Press latency: counting the first clk edge that samples btn_raw high as edge 1, pulse SHALL be high in the cycle after edge DB_CYCLES+3 (default: after edge 6).
REQ-016 At most one bit of pulse SHALL be high in any cycle.
REQ-017 When several requests occur in the same cycle, only the lowest-index bit SHALL pulse; the others SHALL be dropped, not deferred.
REQ-018 any_pulse SHALL equal the OR of pulse in the same cycle.
REQ-019 held SHALL still follow the debounced level for channels whose request was dropped.
REQ-020 Holding a button SHALL NOT produce more than one pulse, except as allowed by REQ-026.

Reset
REQ-021 While rst is high at a clk edge, the following SHALL clear to 0: synchronizer flops, held, counters, repeat state, pulse, any_pulse.
REQ-022 A button held through reset SHALL be treated as a new press after rst deasserts, and SHALL pulse with the REQ-015 latency counted from the first post-reset edge.
REQ-023 rst asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse in the cycle after the reset edge.

Configuration
REQ-024 The macro BTN_AUTO_REPEAT_EN SHALL select whether auto-repeat is compiled in.
REQ-025 Without BTN_AUTO_REPEAT_EN, no repeat counter SHALL exist, and each press SHALL give exactly one pulse.
REQ-026 With BTN_AUTO_REPEAT_EN defined, each add channel (bits 0..3) SHALL have a 12-bit repeat counter and a state machine:
- States: IDLE, DELAY, REPEAT.
- IDLE -> DELAY on a rising edge of held.
- DELAY -> REPEAT after REPEAT_DELAY cycles held; a request is raised on entry.
- REPEAT raises a request every REPEAT_PERIOD cycles.
- Any state -> IDLE when held falls.
REQ-027 rst1 and rst2 (bits 4..5) SHALL never auto-repeat.
REQ-028 Repeat requests SHALL obey the REQ-016/REQ-017 arbitration.
REQ-029 A repeat request dropped by arbitration SHALL NOT reset the repeat timing.

Verification
REQ-030 Scenario: clean add1 press for 20 cycles, defaults -> pulse = 6'b000001 for one cycle, after edge 6; held[0] high through the press.
REQ-031 Scenario: 2-cycle high glitch on bit2 -> held and pulse stay 0.
REQ-032 Scenario: bit3 and bit5 go high on the same edge -> single pulse 6'b001000; held = 6'b101000 from then on.
REQ-033 Scenario: bit1 held high during rst, then rst drops -> exactly one pulse 6'b000010, after post-reset edge 6.
REQ-034 Scenario: add4 held 200 cycles, with macro -> pulses at press, at +100 cycles after held rises, then every 25 cycles (5 total); without macro -> 1 pulse.
REQ-035 Scenario: bit4 held 200 cycles, with macro -> exactly 1 pulse.
